// File: rtl/picorv32_vec_lsu_pkg.sv
// Shared definitions for the strided vector LSU: SEW codes, FSM states and
// the per-SEW lane mask helpers used by the top and the lane aligner.
package picorv32_vec_lsu_pkg;

  localparam logic [1:0] SEW_8   = 2'b00;
  localparam logic [1:0] SEW_16  = 2'b01;
  localparam logic [1:0] SEW_32  = 2'b10;
  localparam logic [1:0] SEW_ILL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_SWAIT,
    S_MEM,
    S_LOUT,
    S_ADV,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic [3:0] sew_strb(input logic [1:0] sew);
    case (sew)
      SEW_8:   sew_strb = 4'b0001;
      SEW_16:  sew_strb = 4'b0011;
      default: sew_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] sew_mask(input logic [1:0] sew);
    case (sew)
      SEW_8:   sew_mask = 32'h0000_00ff;
      SEW_16:  sew_mask = 32'h0000_ffff;
      default: sew_mask = 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/picorv32_vec_lsu_lane_align.sv
// Combinational byte-lane alignment: extracts a load element from a memory
// word and positions a store element plus its byte strobes within the word.
module picorv32_vec_lsu_lane_align
  import picorv32_vec_lsu_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  sew,
  input  logic [31:0] rdata,
  input  logic [31:0] st_data,
  output logic [31:0] ld_elem,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  logic [4:0] shamt;

  assign shamt = {lane, 3'b000};

  // Store data is masked to SEW first so stray upper bits never reach other lanes
  assign ld_elem = (rdata >> shamt) & sew_mask(sew);
  assign wdata   = (st_data & sew_mask(sew)) << shamt;
  assign wstrb   = sew_strb(sew) << lane;

endmodule

// File: rtl/picorv32_vec_lsu.sv
// Strided vector load/store engine: walks vl elements from base by a signed
// byte stride, issuing one word access per element on the vector memory port.
module picorv32_vec_lsu
  import picorv32_vec_lsu_pkg::*;
#(
  parameter int VL_W = 6
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [31:0]     req_base,
  input  logic [31:0]     req_stride,
  input  logic [VL_W-1:0] req_vl,
  input  logic [1:0]      req_sew,
  output logic            ld_valid,
  input  logic            ld_ready,
  output logic [31:0]     ld_data,
  output logic [VL_W-1:0] ld_idx,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [31:0]     st_data,
  output logic            done,
  output logic            err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [31:0]     mem_rdata
);

  state_t          state, next_state;
  logic [31:0]     ea, stride;
  logic [VL_W-1:0] vl, idx;
  logic [1:0]      sew;
  logic            store;
  logic            misaligned, enter_mem;
  logic [31:0]     al_ld_elem, al_wdata;
  logic [3:0]      al_wstrb;

  picorv32_vec_lsu_lane_align u_align (
    .lane    (ea[1:0]),
    .sew     (sew),
    .rdata   (mem_rdata),
    .st_data (st_data),
    .ld_elem (al_ld_elem),
    .wdata   (al_wdata),
    .wstrb   (al_wstrb)
  );

  assign misaligned = (sew == SEW_16 && ea[0]) || (sew == SEW_32 && |ea[1:0]);
  assign enter_mem  = (state != S_MEM) && (next_state == S_MEM);
  assign ld_idx     = idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (req_valid) next_state = S_CHK;
      S_CHK: begin
        if (idx == vl)                         next_state = S_DONE;
        else if (sew == SEW_ILL || misaligned) next_state = S_ERR;
        else if (store)                        next_state = S_SWAIT;
        else                                   next_state = S_MEM;
      end
      S_SWAIT: if (st_valid) next_state = S_MEM;
      S_MEM:   if (mem_ready) next_state = store ? S_ADV : S_LOUT;
      S_LOUT:  if (ld_ready) next_state = S_ADV;
      S_ADV:   next_state = S_CHK;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    ld_valid  = 1'b0;
    st_ready  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE:  req_ready = 1'b1;
      S_SWAIT: st_ready  = 1'b1;
      S_LOUT:  ld_valid  = 1'b1;
      S_DONE:  done      = 1'b1;
      S_ERR:   err       = 1'b1;
      default: ;
    endcase
  end

  // Bus outputs are registered on entry to MEM so they stay stable until mem_ready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ea        <= '0;
      stride    <= '0;
      vl        <= '0;
      idx       <= '0;
      sew       <= SEW_8;
      store     <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      ld_data   <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        ea     <= req_base;
        stride <= req_stride;
        vl     <= req_vl;
        sew    <= req_sew;
        store  <= req_store;
        idx    <= '0;
      end
      if (enter_mem) begin
        mem_valid <= 1'b1;
        mem_addr  <= {ea[31:2], 2'b00};
        mem_wdata <= store ? al_wdata : 32'h0;
        mem_wstrb <= store ? al_wstrb : 4'b0000;
      end
      if (state == S_MEM && mem_ready) begin
        mem_valid <= 1'b0;
        if (!store) ld_data <= al_ld_elem;
      end
      if (state == S_ADV) begin
        ea  <= ea + stride;
        idx <= idx + VL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_picorv32_vec_lsu.sv
// Directed bench for the strided vector LSU with a zero-wait word memory model.
module tb_picorv32_vec_lsu;

  localparam logic [1:0] T_SEW8 = 2'b00, T_SEW16 = 2'b01, T_SEW32 = 2'b10, T_SEWX = 2'b11;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_store;
  logic [31:0] req_base, req_stride;
  logic [5:0]  req_vl;
  logic [1:0]  req_sew;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_data;
  logic [5:0]  ld_idx;
  logic        st_valid, st_ready;
  logic [31:0] st_data;
  logic        done, err;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic [31:0] mem [0:511];
  logic [31:0] acc_addr[$], acc_wdata[$], ld_data_q[$];
  logic [3:0]  acc_wstrb[$];
  logic [5:0]  ld_idx_q[$];
  int          ld_cyc_q[$];
  int          cyc = 0, done_cnt = 0, err_cnt = 0;
  int          pass_cnt = 0, check_cnt = 0;

  picorv32_vec_lsu #(.VL_W(6)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_base(req_base), .req_stride(req_stride), .req_vl(req_vl), .req_sew(req_sew),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_idx(ld_idx),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .done(done), .err(err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after it sees mem_valid and logs every access
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
    end else if (mem_valid && !mem_ready) begin
      acc_addr.push_back(mem_addr);
      acc_wdata.push_back(mem_wdata);
      acc_wstrb.push_back(mem_wstrb);
      mem_rdata <= mem[mem_addr[10:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[10:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_ready <= 1'b1;
    end else begin
      mem_ready <= 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (resetn && done) done_cnt++;
    if (resetn && err) err_cnt++;
    if (resetn && ld_valid && ld_ready) begin
      ld_data_q.push_back(ld_data);
      ld_idx_q.push_back(ld_idx);
      ld_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_logs();
    acc_addr.delete(); acc_wdata.delete(); acc_wstrb.delete();
    ld_data_q.delete(); ld_idx_q.delete(); ld_cyc_q.delete();
  endtask

  task automatic issue(input logic store, input logic [31:0] base, input logic [31:0] stride,
                       input logic [5:0] vl, input logic [1:0] sew);
    @(negedge clk);
    req_store = store; req_base = base; req_stride = stride; req_vl = vl; req_sew = sew;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    int start;
    start = done_cnt + err_cnt;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done_cnt + err_cnt > start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    got = {req_ready, ld_valid, st_ready, done, err, mem_valid, mem_wstrb != 4'b0, 1'b0};
    check_cnt++;
    if (got !== 8'b1000_0000) $display("[TB] FAIL reset_ctrl: got %b expected 10000000", got);
    else pass_cnt++;
    check_cnt++;
    if (mem_addr !== 32'h0) $display("[TB] FAIL reset_addr: got %h expected 00000000", mem_addr);
    else pass_cnt++;
    check_cnt++;
    if (mem_wdata !== 32'h0) $display("[TB] FAIL reset_wdata: got %h expected 00000000", mem_wdata);
    else pass_cnt++;
    check_cnt++;
    if (ld_data !== 32'h0) $display("[TB] FAIL reset_ld_data: got %h expected 00000000", ld_data);
    else pass_cnt++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_sew8();
    logic [7:0] exp8 [16];
    bit ok;
    int d0, gap;
    exp8 = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h00, 8'h01, 8'h03, 8'h01,
             8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_logs(); ld_ready = 1'b1; d0 = done_cnt;
    issue(1'b0, 32'd400, 32'd1, 6'd16, T_SEW8);
    wait_end(ok);
    check_cnt++;
    if (!ok) $display("[TB] FAIL load8_timeout: got no end expected done"); else pass_cnt++;
    check_cnt++;
    if (ld_data_q.size() != 16) $display("[TB] FAIL load8_count: got %0d expected 16", ld_data_q.size());
    else pass_cnt++;
    for (int i = 0; i < ld_data_q.size() && i < 16; i++) begin
      check_cnt++;
      if (ld_data_q[i] !== {24'h0, exp8[i]} || ld_idx_q[i] !== 6'(i))
        $display("[TB] FAIL load8_elem%0d: got %h idx %0d expected %h idx %0d",
                 i, ld_data_q[i], ld_idx_q[i], exp8[i], i);
      else pass_cnt++;
    end
    check_cnt++;
    if (acc_addr.size() != 16) $display("[TB] FAIL load8_accesses: got %0d expected 16", acc_addr.size());
    else pass_cnt++;
    for (int i = 0; i < acc_addr.size() && i < 16; i++) begin
      check_cnt++;
      if (acc_addr[i] !== 32'(400 + 4 * (i / 4)) || acc_wstrb[i] !== 4'b0000)
        $display("[TB] FAIL load8_addr%0d: got %0d strb %b expected %0d strb 0000",
                 i, acc_addr[i], acc_wstrb[i], 400 + 4 * (i / 4));
      else pass_cnt++;
    end
    gap = (ld_cyc_q.size() >= 2) ? ld_cyc_q[1] - ld_cyc_q[0] : -1;
    check_cnt++;
    if (gap != 5) $display("[TB] FAIL load8_latency: got %0d expected 5", gap); else pass_cnt++;
    check_cnt++;
    if (done_cnt - d0 != 1) $display("[TB] FAIL load8_done: got %0d expected 1", done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_store_sew8();
    logic [31:0] expw [4];
    logic [3:0]  exps [4];
    bit ok;
    expw = '{32'h0000_00AB, 32'h0000_AB00, 32'h00AB_0000, 32'hAB00_0000};
    exps = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    clear_logs(); st_data = 32'h0000_00AB; st_valid = 1'b1;
    issue(1'b1, 32'd800, 32'd1, 6'd4, T_SEW8);
    wait_end(ok);
    st_valid = 1'b0;
    check_cnt++;
    if (!ok || acc_addr.size() != 4)
      $display("[TB] FAIL store8_count: got %0d accesses expected 4", acc_addr.size());
    else pass_cnt++;
    for (int i = 0; i < acc_addr.size() && i < 4; i++) begin
      check_cnt++;
      if (acc_addr[i] !== 32'd800 || acc_wstrb[i] !== exps[i] || acc_wdata[i] !== expw[i])
        $display("[TB] FAIL store8_acc%0d: got %0d/%b/%h expected 800/%b/%h",
                 i, acc_addr[i], acc_wstrb[i], acc_wdata[i], exps[i], expw[i]);
      else pass_cnt++;
    end
    check_cnt++;
    if (mem[200] !== 32'hABAB_ABAB) $display("[TB] FAIL store8_mem: got %h expected abababab", mem[200]);
    else pass_cnt++;
  endtask

  task automatic test_load_sew32_neg();
    logic [31:0] expd [3];
    bit ok;
    expd = '{32'h8877_6655, 32'h4433_2211, 32'h0103_0100};
    clear_logs(); ld_ready = 1'b1;
    issue(1'b0, 32'd412, 32'hFFFF_FFFC, 6'd3, T_SEW32);
    wait_end(ok);
    check_cnt++;
    if (!ok || ld_data_q.size() != 3 || acc_addr.size() != 3)
      $display("[TB] FAIL load32_count: got %0d elems %0d accesses expected 3 3",
               ld_data_q.size(), acc_addr.size());
    else pass_cnt++;
    for (int i = 0; i < ld_data_q.size() && i < acc_addr.size() && i < 3; i++) begin
      check_cnt++;
      if (acc_addr[i] !== 32'(412 - 4 * i) || ld_data_q[i] !== expd[i] || ld_idx_q[i] !== 6'(i))
        $display("[TB] FAIL load32_elem%0d: got %0d/%h/%0d expected %0d/%h/%0d",
                 i, acc_addr[i], ld_data_q[i], ld_idx_q[i], 412 - 4 * i, expd[i], i);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_sew16();
    bit ok;
    clear_logs(); ld_ready = 1'b1;
    issue(1'b0, 32'd402, 32'd2, 6'd2, T_SEW16);
    wait_end(ok);
    check_cnt++;
    if (!ok || ld_data_q.size() != 2 || acc_addr.size() != 2)
      $display("[TB] FAIL load16_count: got %0d elems expected 2", ld_data_q.size());
    else pass_cnt++;
    if (ld_data_q.size() == 2 && acc_addr.size() == 2) begin
      check_cnt++;
      if (acc_addr[0] !== 32'd400 || ld_data_q[0] !== 32'h0000_0201)
        $display("[TB] FAIL load16_upper: got %0d/%h expected 400/00000201", acc_addr[0], ld_data_q[0]);
      else pass_cnt++;
      check_cnt++;
      if (acc_addr[1] !== 32'd404 || ld_data_q[1] !== 32'h0000_0100)
        $display("[TB] FAIL load16_lower: got %0d/%h expected 404/00000100", acc_addr[1], ld_data_q[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] bases [3];
    logic [1:0]  sews [3];
    bit ok;
    int d0, e0;
    bases = '{32'd402, 32'd401, 32'd400};
    sews  = '{T_SEW32, T_SEW16, T_SEWX};
    for (int k = 0; k < 3; k++) begin
      clear_logs(); d0 = done_cnt; e0 = err_cnt;
      issue(1'b0, bases[k], 32'd4, 6'd3, sews[k]);
      wait_end(ok);
      check_cnt++;
      if (!ok || err_cnt - e0 != 1 || done_cnt - d0 != 0 || acc_addr.size() != 0)
        $display("[TB] FAIL err_case%0d: got err %0d done %0d acc %0d expected 1 0 0",
                 k, err_cnt - e0, done_cnt - d0, acc_addr.size());
      else pass_cnt++;
    end
  endtask

  task automatic test_vl0();
    int d0;
    clear_logs(); d0 = done_cnt;
    @(negedge clk);
    req_store = 1'b0; req_base = 32'd400; req_stride = 32'd4; req_vl = 6'd0; req_sew = T_SEW32;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_cnt++;
    if (done !== 1'b0) $display("[TB] FAIL vl0_early: got %b expected 0", done); else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (done !== 1'b1) $display("[TB] FAIL vl0_done: got %b expected 1", done); else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (done !== 1'b0 || req_ready !== 1'b1 || acc_addr.size() != 0 || done_cnt - d0 != 1)
      $display("[TB] FAIL vl0_after: got done %b ready %b acc %0d pulses %0d expected 0 1 0 1",
               done, req_ready, acc_addr.size(), done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit found;
    int d0, e0;
    clear_logs(); ld_ready = 1'b1; found = 1'b0;
    issue(1'b0, 32'd400, 32'd4, 6'd2, T_SEW32);
    for (int c = 0; c < 20; c++) begin
      if (mem_valid === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check_cnt++;
    if (!found) $display("[TB] FAIL rstmid_mem_valid: got 0 expected 1"); else pass_cnt++;
    d0 = done_cnt; e0 = err_cnt;
    #2 resetn = 1'b0;
    #1;
    check_cnt++;
    if (mem_valid !== 1'b0 || req_ready !== 1'b1)
      $display("[TB] FAIL rstmid_async: got mem_valid %b ready %b expected 0 1", mem_valid, req_ready);
    else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_cnt++;
    if (done_cnt != d0 || err_cnt != e0 || req_ready !== 1'b1 || mem_valid !== 1'b0)
      $display("[TB] FAIL rstmid_after: got done %0d err %0d ready %b expected 0 0 1",
               done_cnt - d0, err_cnt - e0, req_ready);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit found, ok;
    int acc0;
    clear_logs(); ld_ready = 1'b0; found = 1'b0;
    issue(1'b0, 32'd400, 32'd1, 6'd2, T_SEW8);
    for (int c = 0; c < 20; c++) begin
      if (ld_valid === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check_cnt++;
    if (!found) $display("[TB] FAIL bp_ld_valid: got 0 expected 1"); else pass_cnt++;
    acc0 = acc_addr.size();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_cnt++;
      if (ld_valid !== 1'b1 || ld_data !== 32'h01 || ld_idx !== 6'd0 ||
          mem_valid !== 1'b0 || acc_addr.size() != acc0)
        $display("[TB] FAIL bp_hold%0d: got %b/%h/%0d/%b expected 1/00000001/0/0",
                 c, ld_valid, ld_data, ld_idx, mem_valid);
      else pass_cnt++;
    end
    ld_ready = 1'b1;
    wait_end(ok);
    check_cnt++;
    if (!ok || ld_data_q.size() != 2 || ld_data_q[ld_data_q.size()-1] !== 32'h02)
      $display("[TB] FAIL bp_resume: got %0d elems expected 2 ending 00000002", ld_data_q.size());
    else pass_cnt++;
  endtask

  task automatic test_store_stall();
    bit ok;
    clear_logs(); st_valid = 1'b0; st_data = 32'hFFFF_FF5A;
    issue(1'b1, 32'd808, 32'd1, 6'd1, T_SEW8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_cnt++;
      if (mem_valid !== 1'b0 || st_ready !== 1'b1 || acc_addr.size() != 0)
        $display("[TB] FAIL stall%0d: got mem_valid %b st_ready %b expected 0 1", c, mem_valid, st_ready);
      else pass_cnt++;
    end
    st_valid = 1'b1;
    wait_end(ok);
    st_valid = 1'b0;
    check_cnt++;
    if (!ok || acc_addr.size() != 1) $display("[TB] FAIL stall_count: got %0d expected 1", acc_addr.size());
    else pass_cnt++;
    if (acc_addr.size() == 1) begin
      check_cnt++;
      if (acc_addr[0] !== 32'd808 || acc_wstrb[0] !== 4'b0001 || acc_wdata[0] !== 32'h0000_005A)
        $display("[TB] FAIL stall_acc: got %0d/%b/%h expected 808/0001/0000005a",
                 acc_addr[0], acc_wstrb[0], acc_wdata[0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    req_valid = 1'b0; req_store = 1'b0; req_base = '0; req_stride = '0; req_vl = '0; req_sew = '0;
    ld_ready = 1'b1; st_valid = 1'b0; st_data = '0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[100] = 32'h0201_0201;
    mem[101] = 32'h0103_0100;
    mem[102] = 32'h4433_2211;
    mem[103] = 32'h8877_6655;
    test_reset();
    test_load_sew8();
    test_store_sew8();
    test_load_sew32_neg();
    test_load_sew16();
    test_errors();
    test_vl0();
    test_reset_mid();
    test_backpressure();
    test_store_stall();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
